// File: rtl/sine_pkg.sv
// Shared definitions for the sine wave analyzer: default widths, state encoding
// and the 24-sample reference sine table that the companion generator plays out.
package sine_pkg;

    localparam int SAMPLE_W_DFLT = 8;

    localparam logic ST_SEEK    = 1'b0;
    localparam logic ST_MEASURE = 1'b1;

    typedef enum logic {
        S_SEEK    = ST_SEEK,
        S_MEASURE = ST_MEASURE
    } state_t;

    // One full period, 24*sin(2*pi*k/24) rounded; symmetric so a cycle sums to zero.
    localparam logic signed [SAMPLE_W_DFLT-1:0] REF_TABLE [0:23] = '{
        8'sd0,   8'sd6,   8'sd12,  8'sd17,  8'sd21,  8'sd23,
        8'sd24,  8'sd23,  8'sd21,  8'sd17,  8'sd12,  8'sd6,
        8'sd0,  -8'sd6,  -8'sd12, -8'sd17, -8'sd21, -8'sd23,
       -8'sd24, -8'sd23, -8'sd21, -8'sd17, -8'sd12, -8'sd6
    };

    function automatic logic signed [SAMPLE_W_DFLT-1:0] ref_sample(input logic [4:0] idx);
        return REF_TABLE[idx];
    endfunction

endpackage

// File: rtl/zero_cross_det.sv
// Rising zero-crossing detector: remembers whether the last accepted sample was
// negative and flags an accepted non-negative sample that follows it.
module zero_cross_det
    import sine_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DFLT
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    output logic                       crossing,
    output logic                       prev_neg
);

    logic prev_neg_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            prev_neg_q <= 1'b0;
        end else if (sample_valid) begin
            prev_neg_q <= sample_in[SAMPLE_W-1];
        end
    end

    assign crossing = sample_valid && prev_neg_q && !sample_in[SAMPLE_W-1];
    assign prev_neg = prev_neg_q;

endmodule

// File: rtl/sine_wave_analyzer.sv
// Period / peak / lock analyzer for a signed sample stream. Optional per-cycle
// sample sum output is compiled in with SINE_ANALYZER_DC_SUM_EN.
module sine_wave_analyzer
    import sine_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DFLT,
    parameter int PERIOD_W   = 8,
    parameter int MAX_PERIOD = 64,
    parameter int LOCK_COUNT = 2
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    output logic                       meas_valid,
    output logic [PERIOD_W-1:0]        period,
    output logic signed [SAMPLE_W-1:0] peak_pos,
    output logic signed [SAMPLE_W-1:0] peak_neg,
    output logic                       locked,
    output logic                       timeout_err
`ifdef SINE_ANALYZER_DC_SUM_EN
    ,
    output logic signed [SAMPLE_W+PERIOD_W-1:0] dc_sum
`endif
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] CNT_TC   = PERIOD_W'(MAX_PERIOD - 1);
    localparam logic [MC_W-1:0]     MC_ONE   = MC_W'(1);
    localparam logic [MC_W-1:0]     MC_LOCK  = MC_W'(LOCK_COUNT);

    state_t                       state_q;
    logic [PERIOD_W-1:0]          count_q, count_d;
    logic signed [SAMPLE_W-1:0]   run_max_q, run_max_d;
    logic signed [SAMPLE_W-1:0]   run_min_q, run_min_d;
    logic [PERIOD_W-1:0]          period_q;
    logic signed [SAMPLE_W-1:0]   peak_pos_q, peak_neg_q;
    logic [MC_W-1:0]              match_cnt_q, match_cnt_d;
    logic                         meas_valid_q, timeout_q, locked_q;
    logic                         crossing;
    logic                         unused_prev_neg;

    zero_cross_det #(.SAMPLE_W(SAMPLE_W)) u_zcd (
        .Clk          (Clk),
        .Rst          (Rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .crossing     (crossing),
        .prev_neg     (unused_prev_neg)
    );

`ifdef SINE_ANALYZER_DC_SUM_EN
    localparam int ACC_W = SAMPLE_W + PERIOD_W;
    logic signed [ACC_W-1:0] acc_q, acc_d, dc_sum_q;
    assign acc_d  = acc_q + ACC_W'(sample_in);
    assign dc_sum = dc_sum_q;
`endif

    always_comb begin
        run_max_d = (sample_in > run_max_q) ? sample_in : run_max_q;
        run_min_d = (sample_in < run_min_q) ? sample_in : run_min_q;
        count_d   = count_q + CNT_ONE;
        // Compare against the period being replaced, before it is overwritten.
        if (count_q == period_q) begin
            match_cnt_d = (match_cnt_q >= MC_LOCK) ? MC_LOCK : match_cnt_q + MC_ONE;
        end else begin
            match_cnt_d = MC_ONE;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= S_SEEK;
            count_q      <= '0;
            run_max_q    <= '0;
            run_min_q    <= '0;
            period_q     <= '0;
            peak_pos_q   <= '0;
            peak_neg_q   <= '0;
            match_cnt_q  <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            locked_q     <= 1'b0;
`ifdef SINE_ANALYZER_DC_SUM_EN
            acc_q        <= '0;
            dc_sum_q     <= '0;
`endif
        end else begin
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            if (sample_valid) begin
                case (state_q)
                    S_SEEK: begin
                        if (crossing) begin
                            state_q   <= S_MEASURE;
                            count_q   <= CNT_ONE;
                            run_max_q <= sample_in;
                            run_min_q <= sample_in;
`ifdef SINE_ANALYZER_DC_SUM_EN
                            acc_q     <= ACC_W'(sample_in);
`endif
                        end
                    end
                    S_MEASURE: begin
                        if (crossing) begin
                            period_q     <= count_q;
                            peak_pos_q   <= run_max_q;
                            peak_neg_q   <= run_min_q;
                            meas_valid_q <= 1'b1;
                            match_cnt_q  <= match_cnt_d;
                            locked_q     <= (match_cnt_d >= MC_LOCK);
                            count_q      <= CNT_ONE;
                            run_max_q    <= sample_in;
                            run_min_q    <= sample_in;
`ifdef SINE_ANALYZER_DC_SUM_EN
                            dc_sum_q     <= acc_q;
                            acc_q        <= ACC_W'(sample_in);
`endif
                        end else if (count_q == CNT_TC) begin
                            timeout_q    <= 1'b1;
                            locked_q     <= 1'b0;
                            match_cnt_q  <= '0;
                            state_q      <= S_SEEK;
                        end else begin
                            count_q      <= count_d;
                            run_max_q    <= run_max_d;
                            run_min_q    <= run_min_d;
`ifdef SINE_ANALYZER_DC_SUM_EN
                            acc_q        <= acc_d;
`endif
                        end
                    end
                    default: state_q <= S_SEEK;
                endcase
            end
        end
    end

    assign meas_valid  = meas_valid_q;
    assign period      = period_q;
    assign peak_pos    = peak_pos_q;
    assign peak_neg    = peak_neg_q;
    assign locked      = locked_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_sine_wave_analyzer.sv
// Vector-table bench for sine_wave_analyzer with a measurement scoreboard.
module tb_sine_wave_analyzer;
    import sine_pkg::*;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic signed [7:0] sample_in = '0;
    logic              sample_valid = 1'b0;
    logic              meas_valid;
    logic [7:0]        period;
    logic signed [7:0] peak_pos;
    logic signed [7:0] peak_neg;
    logic              locked;
    logic              timeout_err;
`ifdef SINE_ANALYZER_DC_SUM_EN
    logic signed [15:0] dc_sum;
`endif

    always #5 Clk = ~Clk;

    sine_wave_analyzer dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .meas_valid   (meas_valid),
        .period       (period),
        .peak_pos     (peak_pos),
        .peak_neg     (peak_neg),
        .locked       (locked),
        .timeout_err  (timeout_err)
`ifdef SINE_ANALYZER_DC_SUM_EN
        ,
        .dc_sum       (dc_sum)
`endif
    );

    typedef struct {
        int p;
        int pp;
        int pn;
        int l;
        int dc;
    } exp_t;

    typedef struct {
        logic signed [7:0] s;
        logic              v;
        logic              em;
        logic              et;
        exp_t              x;
    } vec_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   to_q[$];
    int   meas_cyc[$];
    exp_t mx;
    int   tp;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t e(input int p, input int pp, input int pn, input int l, input int dc);
        exp_t r;
        r.p = p; r.pp = pp; r.pn = pn; r.l = l; r.dc = dc;
        return r;
    endfunction

    function automatic void add(input int s, input logic v);
        vec_t r;
        r.s = 8'(s); r.v = v; r.em = 1'b0; r.et = 1'b0; r.x = e(0, 0, 0, 0, 0);
        vecs.push_back(r);
    endfunction

    function automatic void mark(input exp_t x);
        vec_t r;
        r = vecs.pop_back();
        r.em = 1'b1;
        r.x  = x;
        vecs.push_back(r);
    endfunction

    function automatic void mark_to(input int p);
        vec_t r;
        r = vecs.pop_back();
        r.et  = 1'b1;
        r.x.p = p;
        vecs.push_back(r);
    endfunction

    // n table samples stepping by 'step'; the first one optionally carries an expected measurement.
    function automatic void add_loop(input int step, input int n, input logic tog, input int off,
                                     input logic do_mark, input exp_t x);
        for (int i = 0; i < n; i++) begin
            add(int'(ref_sample(5'(i * step))) + off, 1'b1);
            if (i == 0 && do_mark) mark(x);
            if (tog) add(-100, 1'b0);
        end
    endfunction

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge Clk); #1;
            sample_in    = vecs[i].s;
            sample_valid = vecs[i].v;
            if (vecs[i].em) exp_q.push_back(vecs[i].x);
            if (vecs[i].et) to_q.push_back(vecs[i].x.p);
        end
        @(posedge Clk); #1;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (3) @(posedge Clk);
        vecs.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_meas_valid", int'(meas_valid), 0);
        check("rst_period", int'(period), 0);
        check("rst_peak_pos", int'(peak_pos), 0);
        check("rst_peak_neg", int'(peak_neg), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_timeout", int'(timeout_err), 0);
    endtask

    always @(negedge Clk) begin
        cyc++;
        if (!Rst) begin
            if (meas_valid) begin
                meas_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_meas_valid", 1, 0);
                end else begin
                    mx = exp_q.pop_front();
                    check("period", int'(period), mx.p);
                    check("peak_pos", int'(peak_pos), mx.pp);
                    check("peak_neg", int'(peak_neg), mx.pn);
                    check("locked", int'(locked), mx.l);
`ifdef SINE_ANALYZER_DC_SUM_EN
                    check("dc_sum", int'(dc_sum), mx.dc);
`endif
                end
            end
            if (timeout_err) begin
                if (to_q.size() == 0) begin
                    check("unexpected_timeout", 1, 0);
                end else begin
                    tp = to_q.pop_front();
                    check("timeout_period_held", int'(period), tp);
                    check("timeout_locked", int'(locked), 0);
                    check("timeout_no_meas", int'(meas_valid), 0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        repeat (2) @(negedge Clk);
        check_reset_outputs();
        @(posedge Clk); #1;
        Rst = 1'b0;

        // Partial stream with one measurement, then reset mid-cycle
        add_loop(1, 24, 1'b0, 0, 1'b0, e(0, 0, 0, 0, 0));
        add_loop(1, 24, 1'b0, 0, 1'b0, e(0, 0, 0, 0, 0));
        add_loop(1, 10, 1'b0, 0, 1'b1, e(24, 24, -24, 0, 0));
        run_vecs();
        check("pre_rst_period", int'(period), 24);
        @(posedge Clk); #1;
        Rst = 1'b1;
        @(negedge Clk);
        check_reset_outputs();
        @(posedge Clk); #1;
        Rst = 1'b0;

        // Continuous stream: two fresh crossings before the first measurement, lock on the 2nd
        add_loop(1, 24, 1'b0, 0, 1'b0, e(0, 0, 0, 0, 0));
        add_loop(1, 24, 1'b0, 0, 1'b0, e(0, 0, 0, 0, 0));
        add_loop(1, 24, 1'b0, 0, 1'b1, e(24, 24, -24, 0, 0));
        add_loop(1, 24, 1'b0, 0, 1'b1, e(24, 24, -24, 1, 0));
        add_loop(1, 24, 1'b0, 0, 1'b1, e(24, 24, -24, 1, 0));
        run_vecs();

        // Stalled stream: valid toggles, garbage on stall cycles
        add_loop(1, 24, 1'b1, 0, 1'b1, e(24, 24, -24, 1, 0));
        add_loop(1, 24, 1'b1, 0, 1'b1, e(24, 24, -24, 1, 0));
        run_vecs();
        if (meas_cyc.size() >= 2)
            check("meas_spacing_stalled", meas_cyc[$] - meas_cyc[$-1], 48);
        else
            check("meas_count_stalled", meas_cyc.size(), 2);

        // Period change 24 -> 12 drops lock, relocks after the next equal period
        add_loop(2, 12, 1'b0, 0, 1'b1, e(24, 24, -24, 1, 0));
        add_loop(2, 12, 1'b0, 0, 1'b1, e(12, 24, -24, 0, 0));
        add_loop(2, 12, 1'b0, 0, 1'b1, e(12, 24, -24, 1, 0));
        add_loop(2, 12, 1'b0, 0, 1'b1, e(12, 24, -24, 1, 0));
        run_vecs();

        // Crossing, then +10 held: timeout on the 64th sample since the crossing
        add(0, 1'b1);
        mark(e(12, 24, -24, 1, 0));
        for (int i = 0; i < 64; i++) begin
            add(10, 1'b1);
            if (i == 62) mark_to(12);
        end
        // Back in SEEK: needs two crossings again before measuring
        add_loop(1, 24, 1'b0, 0, 1'b0, e(0, 0, 0, 0, 0));
        add_loop(1, 24, 1'b0, 0, 1'b0, e(0, 0, 0, 0, 0));
        add_loop(1, 24, 1'b0, 0, 1'b1, e(24, 24, -24, 0, 0));
        run_vecs();

        // DC-offset stream (+4): same period, shifted peaks, cycle sum 96
        add_loop(1, 24, 1'b0, 4, 1'b1, e(24, 24, -24, 1, 0));
        add_loop(1, 24, 1'b0, 4, 1'b1, e(24, 28, -20, 1, 96));
        add(4, 1'b1);
        mark(e(24, 28, -20, 1, 96));
        run_vecs();

        check("scoreboard_meas_left", exp_q.size(), 0);
        check("scoreboard_timeout_left", to_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
